lu_pipe: RTL and testbench

- Parametrised successor to the 1-bit gate/mux logic unit: WIDTH-bit bitwise logic unit, 8 ops selected by a 3-bit opcode.
- Two-stage registered pipeline with valid/ready handshake on both sides; accumulate mode feeds the last result back as operand b.
- Sits between operand source and register writeback in the datapath exercises; replaces the combinational 4-op unit.

---
 rtl/lu_pipe.sv | 155 +++++++++++++++
 tb/tb_lu_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_pipe.sv
// rtl/lu_pipe.sv - two-stage WIDTH-bit bitwise logic unit with valid/ready handshake and accumulator
// Optional macro LU_PIPE_FLAGS_EN adds registered zero/parity flags next to result.
module lu_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc
`ifdef LU_PIPE_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  // Low four opcodes keep the old gate/mux unit encoding so WIDTH=1 is a drop-in.
  function automatic logic [WIDTH-1:0] lu_op(input logic [2:0] o,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = ~(x | y);
      3'b001:  r = x | y;
      3'b010:  r = ~(x & y);
      3'b011:  r = x & y;
      3'b100:  r = x ^ y;
      3'b101:  r = ~(x ^ y);
      3'b110:  r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic [2:0]       op1_q, op1_d;
  logic             acc_sel1_q, acc_sel1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`ifdef LU_PIPE_FLAGS_EN
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
`endif

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] new_result;

  // Handshake, stage advance and next-state for both stages and the accumulator.
  // The accumulator is read at stage-2 compute time, so a back-to-back acc_sel
  // beat sees the previous beat's result without a bubble.
  always_comb begin
    s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready   = !s1_valid_q || s2_load;
    s1_load    = in_valid && in_ready;

    operand_b  = acc_sel1_q ? acc_q : b1_q;
    new_result = lu_op(op1_q, a1_q, operand_b);

    s1_valid_d = s1_valid_q;
    a1_d       = a1_q;
    b1_d       = b1_q;
    op1_d      = op1_q;
    acc_sel1_d = acc_sel1_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      a1_d       = a;
      b1_d       = b;
      op1_d      = op;
      acc_sel1_d = acc_sel;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = new_result;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // A stage-2 load takes priority over a simultaneous clear.
    acc_d = acc_q;
    if (s2_load) begin
      acc_d = new_result;
    end else if (acc_clr) begin
      acc_d = ACC_INIT;
    end

`ifdef LU_PIPE_FLAGS_EN
    zero_d   = zero_q;
    parity_d = parity_q;
    if (s2_load) begin
      zero_d   = (new_result == '0);
      parity_d = ^new_result;
    end
`endif
  end

  // Pipeline and accumulator registers; reset discards all in-flight beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      a1_q       <= '0;
      b1_q       <= '0;
      op1_q      <= '0;
      acc_sel1_q <= 1'b0;
      result_q   <= '0;
      acc_q      <= ACC_INIT;
`ifdef LU_PIPE_FLAGS_EN
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      op1_q      <= op1_d;
      acc_sel1_q <= acc_sel1_d;
      result_q   <= result_d;
      acc_q      <= acc_d;
`ifdef LU_PIPE_FLAGS_EN
      zero_q     <= zero_d;
      parity_q   <= parity_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign acc       = acc_q;
`ifdef LU_PIPE_FLAGS_EN
  assign zero      = zero_q;
  assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_lu_pipe.sv
// tb/tb_lu_pipe.sv - self-checking bench for lu_pipe (directed tables plus randomized scoreboard)
module tb_lu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         acc_sel;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] acc;
`ifdef LU_PIPE_FLAGS_EN
  logic         zero;
  logic         parity;
`endif

  always #5 clk = ~clk;

  lu_pipe #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .acc_sel  (acc_sel),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .acc      (acc)
`ifdef LU_PIPE_FLAGS_EN
    ,
    .zero     (zero),
    .parity   (parity)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       sel;
  } beat_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: per-bit truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (o)
      3'd0: tt = 4'b0001;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0111;
      3'd3: tt = 4'b1000;
      3'd4: tt = 4'b0110;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    acc_sel  = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b1;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  vec_t       tbl[8];
  logic [7:0] tbl_exp[8] = '{8'h03, 8'hFC, 8'hCF, 8'h30, 8'hCC, 8'h33, 8'h0F, 8'hF0};
  logic [7:0] bp[4]      = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] acc_a[3]   = '{8'h01, 8'h02, 8'h04};
  logic [7:0] acc_exp[3] = '{8'h01, 8'h03, 8'h07};
  beat_t      q[$];

  initial begin
    int   idx;
    int   rx;
    logic take;
    logic [7:0] acc_m;
    logic [7:0] e;
    beat_t bt;

    for (int i = 0; i < 8; i++) tbl[i] = '{8'hF0, 8'h3C, 3'(i), tbl_exp[i]};

    // Reset held two cycles.
    idle();
    out_ready = 1'b1;
    reset     = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 8'h00);
    chk("rst_acc", acc, 8'h00);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    step();

    // All eight opcodes back to back; each result two cycles after its beat.
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1;
        a        = tbl[cyc].a;
        b        = tbl[cyc].b;
        op       = tbl[cyc].op;
      end else idle();
      @(negedge clk);
      chk($sformatf("op_in_ready_%0d", cyc), in_ready, 1);
      if (cyc >= 2 && cyc < 10) begin
        chk($sformatf("op_valid_%0d", cyc - 2), out_valid, 1);
        chk($sformatf("op_result_%0d", cyc - 2), result, tbl[cyc - 2].exp);
      end else begin
        chk($sformatf("op_idle_valid_%0d", cyc), out_valid, 0);
      end
      step();
    end

    // Backpressure: two beats fill the pipe, result frozen, then drain in order.
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = bp[idx];
      op        = 3'd7;
      @(negedge clk);
      take = in_valid && in_ready;
      if (cyc == 3) chk("bp_in_ready_low", in_ready, 0);
      if (cyc >= 2) begin
        chk($sformatf("bp_hold_valid_%0d", cyc), out_valid, 1);
        chk($sformatf("bp_hold_result_%0d", cyc), result, 8'h11);
      end
      step();
      if (take) idx++;
    end
    chk("bp_accepted", idx, 2);
    rx = 0;
    for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
      out_ready = 1'b1;
      in_valid  = (idx < 4);
      a         = (idx < 4) ? bp[idx] : 8'h00;
      @(negedge clk);
      take = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("bp_order_%0d", rx), result, bp[rx]);
        rx++;
      end
      step();
      if (take) idx++;
    end
    chk("bp_delivered", rx, 4);
    idle();
    step();

    // Accumulate: clear, then OR in 01, 02, 04 using the accumulator as b.
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc < 3) begin
        in_valid = 1'b1;
        a        = acc_a[cyc];
        b        = 8'hFF;
        op       = 3'd1;
        acc_sel  = 1'b1;
      end else idle();
      @(negedge clk);
      if (cyc == 0) chk("acc_cleared", acc, 8'h00);
      if (cyc >= 2) begin
        chk($sformatf("acc_valid_%0d", cyc - 2), out_valid, 1);
        chk($sformatf("acc_result_%0d", cyc - 2), result, acc_exp[cyc - 2]);
      end
      step();
    end
    @(negedge clk);
    chk("acc_final", acc, 8'h07);
    step();
    idle();
    step();

    // acc_clr in the same cycle as a stage-2 load: the load wins.
    in_valid = 1'b1;
    a        = 8'h5A;
    op       = 3'd7;
    step();
    idle();
    acc_clr = 1'b1;
    step();
    acc_clr   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("clr_vs_load_acc", acc, 8'h5A);
    chk("clr_vs_load_valid", out_valid, 1);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    @(negedge clk);
    chk("clr_only_acc", acc, 8'h00);
    chk("clr_only_valid", out_valid, 1);
    chk("clr_only_result", result, 8'h5A);
    out_ready = 1'b1;
    step();
    step();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 3'd7;
    a         = 8'h77;
    step();
    a = 8'h88;
    step();
    idle();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_acc", acc, 8'h00);
    chk("midrst_result", result, 8'h00);
    for (int cyc = 0; cyc < 5; cyc++) begin
      step();
      @(negedge clk);
      chk($sformatf("midrst_no_stale_%0d", cyc), out_valid, 0);
    end
    step();

`ifdef LU_PIPE_FLAGS_EN
    // Flags.
    in_valid = 1'b1;
    op = 3'd3; a = 8'hAA; b = 8'h55;
    step();
    op = 3'd4; a = 8'h01; b = 8'h00;
    step();
    idle();
    @(negedge clk);
    chk("flag_and_result", result, 8'h00);
    chk("flag_and_zero", zero, 1);
    chk("flag_and_parity", parity, 0);
    step();
    @(negedge clk);
    chk("flag_xor_zero", zero, 0);
    chk("flag_xor_parity", parity, 1);
    step();
`endif

    // Randomized stream against an in-order scoreboard.
    do_reset();
    acc_m = 8'h00;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc >= 400 && q.size() == 0) break;
      in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 3'($urandom);
      acc_sel   = 1'($urandom);
      out_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rnd_in_ready", in_ready, (q.size() < 2) || out_ready);
      if (q.size() == 0) chk("rnd_empty_valid", out_valid, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_beat", 1, 0);
        end else begin
          bt    = q.pop_front();
          e     = ref_op(bt.op, bt.a, bt.sel ? acc_m : bt.b);
          acc_m = e;
          chk("rnd_result", result, e);
          chk("rnd_acc", acc, e);
`ifdef LU_PIPE_FLAGS_EN
          chk("rnd_zero", zero, (e == 8'h00));
          chk("rnd_parity", parity, ^e);
`endif
        end
      end
      if (in_valid && in_ready) q.push_back('{a, b, op, acc_sel});
      step();
    end
    chk("rnd_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
